t03_wb_multi_manager: RTL and testbench
=======================================

# t03_wb_multi_manager

Parametrised Wishbone classic manager that sits between the t03 core's memory requesters (instruction fetch, data load/store, peripherals) and the single Wishbone bus to the management core. It arbitrates `NUM_CH` independent request channels round-robin and runs one single-beat classic cycle at a time. It returns read data and a one-cycle completion pulse to the granted channel. It adds an optional bus watchdog that the single-channel manager lacks.

## Interface
- `NUM_CH`, 2: number of requester channels (1..8)
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width, multiple of 8; `SEL_W = DATA_W/8`
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles (used only with the macro)
- `clock` input 1: sole clock, rising edge
- `reset` input 1: asynchronous, active-high
- `req_read_i` input NUM_CH: per-channel read request, level, held until done
- `req_write_i` input NUM_CH: per-channel write request, level, held until done
- `req_adr_i` input NUM_CH×ADDR_W: per-channel address
- `req_dat_i` input NUM_CH×DATA_W: per-channel write data
- `req_sel_i` input NUM_CH×SEL_W: per-channel byte enables
- `req_busy_o` output NUM_CH: channel has an outstanding request not yet completed
- `req_done_o` output NUM_CH: one-cycle completion pulse
- `req_err_o` output NUM_CH: one-cycle error pulse, coincident with done
- `req_dat_o` output DATA_W: last read data, shared by all channels
- `ADR_O` output ADDR_W, `DAT_O` output DATA_W, `SEL_O` output SEL_W, `WE_O`/`STB_O`/`CYC_O` output 1: Wishbone manager side
- `DAT_I` input DATA_W, `ACK_I` input 1: Wishbone subordinate response

## Operation
- States: IDLE, BUS, DONE.
- IDLE: pending = `req_read_i | req_write_i`.
  - If any channel is pending, grant the first pending index after `last_grant`, wrapping.
  - Latch the granted channel's ADR, DAT and SEL, and set WE = `req_write_i[g]`.
  - Go to BUS.
  - If read and write are both high on a channel, the write wins.
- BUS: `CYC_O=STB_O=1`; ADR/DAT/SEL/WE stay stable from registers.
  - On `ACK_I`: capture `DAT_I` into `req_dat_o` for reads only; writes leave it unchanged. Go to DONE.
- DONE:
  - `CYC_O=STB_O=0`.
  - `req_done_o[g]=1`; `last_grant<=g`.
  - Go to IDLE unconditionally.
  - The requester deasserts read/write in this cycle; arbitration does not sample requests in DONE.
- `req_busy_o[i] = (req_read_i[i]|req_write_i[i]) & ~req_done_o[i]`.
- `ACK_I` outside BUS is ignored.
- `req_dat_o` holds its value until the next read completes.

## Timing
- Reset values:
  - State IDLE; `CYC_O`, `STB_O` and `WE_O` are 0.
  - `ADR_O`, `DAT_O`, `SEL_O` and `req_dat_o` are 0.
  - `req_done_o` and `req_err_o` are 0.
  - `last_grant = NUM_CH-1`, so channel 0 wins first.
- Reset asserted mid-cycle: `CYC_O` and `STB_O` drop asynchronously. No done or err pulse is produced, and the transaction is lost.
- Request in cycle 0 with the manager IDLE:
  - `CYC_O` is high from cycle 1.
  - If ACK arrives in cycle k ≥ 1, done pulses and `CYC_O` goes low in cycle k+1.
  - Read data is valid on `req_dat_o` in cycle k+1.
- Minimum issue interval is 3 cycles (BUS → DONE → IDLE → BUS).
- Fairness: when all channels are continuously pending, each is served once per NUM_CH transactions.

## Configuration
- Macro: `T03_WB_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUS and increments each BUS cycle.
  - If the count reaches TIMEOUT_CYCLES without ACK, the cycle is aborted: go to DONE with `req_done_o[g]=1` and `req_err_o[g]=1`.
  - On abort, `req_dat_o` is set to all ones if the aborted cycle was a read.
  - If ACK and timeout occur in the same cycle, ACK wins and no error is raised.
- Undefined: no counter; BUS waits indefinitely; `req_err_o` is tied to 0.

## Structure
- Package `t03_wb_pkg`:
  - state enum `wb_state_t` (IDLE/BUS/DONE)
  - default width constants `T03_ADDR_W` and `T03_DATA_W`
- Sub-module `t03_rr_arbiter` (parameter `NUM_CH`):
  - inputs: pending vector, `last_grant`
  - outputs: grant index, grant valid
  - purely combinational

## Test plan
- Single read on ch0, adr 0x3000_0010, ACK after 2 cycles with `DAT_I`=0xCAFE_F00D → CYC high for 2 cycles, WE=0, `req_done_o[0]` pulses, `req_dat_o`=0xCAFE_F00D.
- Write on ch1, dat 0x1234_5678, sel 4'b0011 → DAT_O=0x1234_5678, SEL_O=4'b0011, WE_O=1, `req_dat_o` unchanged.
- Both channels held pending for 4 transactions with immediate ACK → grant order 0,1,0,1 and `CYC_O` low for exactly 2 cycles between bus cycles.
- Read and write both high on ch0 → WE_O=1 (the write is performed).
- With `T03_WB_TIMEOUT_EN` and TIMEOUT_CYCLES=8, read with no ACK → abort after 8 BUS cycles; done and err pulse together; `req_dat_o`=0xFFFF_FFFF. Repeat with ACK on cycle 8 → no error.
- Assert reset during BUS → `CYC_O`/`STB_O` go low immediately, no done pulse; after release, ch0 is granted first.

Source files
------------

// File: rtl/t03_wb_multi_manager_pkg.sv
// Shared types and default widths for the t03 multi-channel Wishbone manager.
// Optional watchdog is enabled by defining T03_WB_TIMEOUT_EN.
package t03_wb_pkg;

    localparam int T03_ADDR_W = 32;
    localparam int T03_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    // Index width that stays legal for a single channel.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/t03_wb_multi_manager_if.sv
// Requester channels plus the Wishbone classic manager port, bundled.
// master = the manager block, slave = requesters and bus subordinate.
interface t03_wb_multi_manager_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [NUM_CH-1:0]             req_read_i;
    logic [NUM_CH-1:0]             req_write_i;
    logic [NUM_CH-1:0][ADDR_W-1:0] req_adr_i;
    logic [NUM_CH-1:0][DATA_W-1:0] req_dat_i;
    logic [NUM_CH-1:0][SEL_W-1:0]  req_sel_i;
    logic [NUM_CH-1:0]             req_busy_o;
    logic [NUM_CH-1:0]             req_done_o;
    logic [NUM_CH-1:0]             req_err_o;
    logic [DATA_W-1:0]             req_dat_o;

    logic [ADDR_W-1:0] ADR_O;
    logic [DATA_W-1:0] DAT_O;
    logic [SEL_W-1:0]  SEL_O;
    logic              WE_O;
    logic              STB_O;
    logic              CYC_O;
    logic [DATA_W-1:0] DAT_I;
    logic              ACK_I;

    modport master (
        input  req_read_i, req_write_i, req_adr_i, req_dat_i, req_sel_i,
        output req_busy_o, req_done_o, req_err_o, req_dat_o,
        output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
        input  DAT_I, ACK_I
    );

    modport slave (
        output req_read_i, req_write_i, req_adr_i, req_dat_i, req_sel_i,
        input  req_busy_o, req_done_o, req_err_o, req_dat_o,
        input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
        output DAT_I, ACK_I
    );

endinterface

// File: rtl/t03_wb_multi_manager_rr_arbiter.sv
// Combinational round-robin pick: first pending channel after last_grant.
module t03_rr_arbiter
    import t03_wb_pkg::*;
#(
    parameter int  NUM_CH = 2,
    localparam int IDX_W  = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant,
    output logic              grant_valid
);

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!grant_valid && pending[(int'(last_grant) + i) % NUM_CH]) begin
                grant       = IDX_W'((int'(last_grant) + i) % NUM_CH);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t03_wb_multi_manager.sv
// Round-robin multi-channel Wishbone classic manager, one single-beat cycle at a time.
// Define T03_WB_TIMEOUT_EN to add the bus watchdog (abort with error pulse).
module t03_wb_multi_manager
    import t03_wb_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = T03_ADDR_W,
    parameter int DATA_W         = T03_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    t03_wb_multi_manager_if.master wb
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = idx_w(NUM_CH);

    wb_state_t         state, state_n;
    logic [IDX_W-1:0]  gnt;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  arb_grant;
    logic              arb_valid;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] rdat_q;
    logic [NUM_CH-1:0] done;
    logic              timeout;

    t03_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .pending     (wb.req_read_i | wb.req_write_i),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

`ifdef T03_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    // cnt holds completed BUS cycles, so the limit hits in the Nth one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state != BUS) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = (state == BUS) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == BUS) begin
            err_q <= timeout && !wb.ACK_I;
        end else if (state == DONE) begin
            err_q <= 1'b0;
        end
    end

    assign wb.req_err_o = done & {NUM_CH{err_q}};
`else
    assign timeout      = 1'b0;
    assign wb.req_err_o = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (arb_valid) state_n = BUS;
            BUS:     if (wb.ACK_I || timeout) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt        <= '0;
            last_grant <= IDX_W'(NUM_CH - 1);
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            rdat_q     <= '0;
        end else begin
            if (state == IDLE && arb_valid) begin
                gnt   <= arb_grant;
                we_q  <= wb.req_write_i[arb_grant];
                adr_q <= wb.req_adr_i[arb_grant];
                dat_q <= wb.req_dat_i[arb_grant];
                sel_q <= wb.req_sel_i[arb_grant];
            end
            if (state == BUS && !we_q) begin
                if (wb.ACK_I) begin
                    rdat_q <= wb.DAT_I;
                end else if (timeout) begin
                    rdat_q <= '1;
                end
            end
            if (state == DONE) begin
                last_grant <= gnt;
            end
        end
    end

    always_comb begin
        done = '0;
        if (state == DONE) done[gnt] = 1'b1;
    end

    assign wb.req_done_o = done;
    assign wb.req_busy_o = (wb.req_read_i | wb.req_write_i) & ~done;
    assign wb.req_dat_o  = rdat_q;
    assign wb.ADR_O      = adr_q;
    assign wb.DAT_O      = dat_q;
    assign wb.SEL_O      = sel_q;
    assign wb.WE_O       = we_q;
    assign wb.CYC_O      = (state == BUS);
    assign wb.STB_O      = (state == BUS);

endmodule

// File: tb/tb_t03_wb_multi_manager.sv
// Scoreboard bench: stimulus queues expected completions, a monitor checks each done pulse.
// Watchdog cases run only when T03_WB_TIMEOUT_EN is defined.
module tb_t03_wb_multi_manager;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    t03_wb_multi_manager_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) m ();

    t03_wb_multi_manager #(
        .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock (clk),
        .reset (rst),
        .wb    (m)
    );

    typedef struct {
        int          ch;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdat;
        logic        err;
        int          len;
        int          gap;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 1;
    logic [31:0] sub_data = 32'h0;
    logic [31:0] model_rdat = 32'h0;

    // bus observation, updated by the monitor
    int          cyc_len = 0;
    int          gap_cnt = 1000;
    int          gap_run = 1000;
    logic        prev_cyc = 1'b0;
    logic        stb_ok = 1'b1;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_tx(input int ch, input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel,
                             input logic [31:0] rdat, input logic err,
                             input int len, input int gap);
        exp_t e;
        e.ch = ch; e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
        e.rdat = rdat; e.err = err; e.len = len; e.gap = gap;
        q.push_back(e);
    endtask

    // Wishbone subordinate: ACK in the ack_delay-th cycle of CYC, never if -1.
    initial begin
        int n;
        n = 0;
        m.ACK_I = 1'b0;
        m.DAT_I = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (m.CYC_O) begin
                n++;
                m.ACK_I = (n == ack_delay);
                m.DAT_I = m.ACK_I ? sub_data : 32'h0;
            end else begin
                n = 0;
                m.ACK_I = 1'b0;
            end
        end
    end

    // Monitor: track bus activity and score every done pulse.
    initial begin
        exp_t        e;
        logic [1:0]  onehot;
        forever begin
            @(negedge clk);
            if (m.CYC_O) begin
                if (!prev_cyc) begin
                    cyc_len = 0;
                    gap_run = gap_cnt;
                    stb_ok  = 1'b1;
                end
                cyc_len++;
                stb_ok  = stb_ok && m.STB_O;
                cap_adr = m.ADR_O;
                cap_dat = m.DAT_O;
                cap_sel = m.SEL_O;
                cap_we  = m.WE_O;
            end else begin
                gap_cnt = prev_cyc ? 1 : gap_cnt + 1;
            end
            prev_cyc = m.CYC_O;
            if (|m.req_done_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(m.req_done_o), 64'h0);
                end else begin
                    e = q.pop_front();
                    onehot = 2'b00;
                    onehot[e.ch] = 1'b1;
                    chk("done_channel", 64'(m.req_done_o), 64'(onehot));
                    chk("err_pulse", 64'(m.req_err_o), e.err ? 64'(onehot) : 64'h0);
                    chk("rdata", 64'(m.req_dat_o), 64'(e.rdat));
                    chk("adr_o", 64'(cap_adr), 64'(e.adr));
                    chk("dat_o", 64'(cap_dat), 64'(e.dat));
                    chk("sel_o", 64'(cap_sel), 64'(e.sel));
                    chk("we_o", 64'(cap_we), 64'(e.we));
                    chk("stb_eq_cyc", 64'(stb_ok), 64'h1);
                    chk("cyc_len", 64'(cyc_len), 64'(e.len));
                    chk("cyc_low_at_done", 64'(m.CYC_O), 64'h0);
                    chk("busy_masked", 64'(m.req_busy_o[e.ch]), 64'h0);
                    if (e.gap >= 0) chk("idle_gap", 64'(gap_run), 64'(e.gap));
                end
            end
        end
    end

    task automatic issue(input int ch, input logic rd, input logic wr,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        logic [1:0] b;
        logic       got;
        b = 2'b00;
        b[ch] = 1'b1;
        m.req_adr_i[ch]   = adr;
        m.req_dat_i[ch]   = dat;
        m.req_sel_i[ch]   = sel;
        m.req_read_i[ch]  = rd;
        m.req_write_i[ch] = wr;
        #1;
        chk("busy_raise", 64'(m.req_busy_o), 64'(b));
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            #1;
            if (m.req_done_o[ch]) got = 1'b1;
        end
        if (!got) chk("done_timeout", 64'h0, 64'h1);
        m.req_read_i[ch]  = 1'b0;
        m.req_write_i[ch] = 1'b0;
    endtask

    // ch0 writes, ch1 reads, each held pending until its quota is served.
    task automatic run_pair(input int n0, input int n1);
        int left0, left1;
        left0 = n0;
        left1 = n1;
        m.req_adr_i[0] = 32'h0000_0100;
        m.req_dat_i[0] = 32'hA0A0_0001;
        m.req_sel_i[0] = 4'hF;
        m.req_adr_i[1] = 32'h0000_0200;
        m.req_dat_i[1] = 32'h0;
        m.req_sel_i[1] = 4'b1100;
        m.req_write_i[0] = (left0 > 0);
        m.req_read_i[1]  = (left1 > 0);
        for (int c = 0; c < 400 && (left0 + left1) > 0; c++) begin
            @(posedge clk);
            #1;
            if (m.req_done_o[0]) begin
                left0--;
                if (left0 == 0) m.req_write_i[0] = 1'b0;
            end
            if (m.req_done_o[1]) begin
                left1--;
                if (left1 == 0) m.req_read_i[1] = 1'b0;
            end
        end
        if ((left0 + left1) > 0) chk("pair_timeout", 64'(left0 + left1), 64'h0);
        m.req_write_i[0] = 1'b0;
        m.req_read_i[1]  = 1'b0;
    endtask

    initial begin
        logic got;
        m.req_read_i  = '0;
        m.req_write_i = '0;
        m.req_adr_i   = '0;
        m.req_dat_i   = '0;
        m.req_sel_i   = '0;

        // reset state
        #12;
        chk("rst_cyc", 64'(m.CYC_O), 64'h0);
        chk("rst_stb", 64'(m.STB_O), 64'h0);
        chk("rst_we", 64'(m.WE_O), 64'h0);
        chk("rst_adr", 64'(m.ADR_O), 64'h0);
        chk("rst_dat", 64'(m.DAT_O), 64'h0);
        chk("rst_sel", 64'(m.SEL_O), 64'h0);
        chk("rst_rdat", 64'(m.req_dat_o), 64'h0);
        chk("rst_done", 64'(m.req_done_o), 64'h0);
        chk("rst_err", 64'(m.req_err_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single read, ACK in second bus cycle
        ack_delay = 2;
        sub_data  = 32'hCAFE_F00D;
        model_rdat = 32'hCAFE_F00D;
        expect_tx(0, 1'b0, 32'h3000_0010, 32'h1111_1111, 4'hF, model_rdat, 1'b0, 2, -1);
        issue(0, 1'b1, 1'b0, 32'h3000_0010, 32'h1111_1111, 4'hF);

        // write on ch1 leaves read data alone
        @(negedge clk);
        ack_delay = 1;
        sub_data  = 32'hDEAD_BEEF;
        expect_tx(1, 1'b1, 32'h3000_0020, 32'h1234_5678, 4'b0011, model_rdat, 1'b0, 1, -1);
        issue(1, 1'b0, 1'b1, 32'h3000_0020, 32'h1234_5678, 4'b0011);

        // fairness with both channels held pending
        @(negedge clk);
        sub_data = 32'h5555_AAAA;
        expect_tx(0, 1'b1, 32'h0000_0100, 32'hA0A0_0001, 4'hF, model_rdat, 1'b0, 1, -1);
        model_rdat = 32'h5555_AAAA;
        expect_tx(1, 1'b0, 32'h0000_0200, 32'h0, 4'b1100, model_rdat, 1'b0, 1, 2);
        expect_tx(0, 1'b1, 32'h0000_0100, 32'hA0A0_0001, 4'hF, model_rdat, 1'b0, 1, 2);
        expect_tx(1, 1'b0, 32'h0000_0200, 32'h0, 4'b1100, model_rdat, 1'b0, 1, 2);
        run_pair(2, 2);

        // read and write together: write wins
        @(negedge clk);
        ack_delay = 3;
        sub_data  = 32'h0F0F_0F0F;
        expect_tx(0, 1'b1, 32'h3000_0040, 32'h7777_0000, 4'b1000, model_rdat, 1'b0, 3, -1);
        issue(0, 1'b1, 1'b1, 32'h3000_0040, 32'h7777_0000, 4'b1000);

`ifdef T03_WB_TIMEOUT_EN
        // watchdog abort on a read with no ACK
        @(negedge clk);
        ack_delay = -1;
        model_rdat = 32'hFFFF_FFFF;
        expect_tx(0, 1'b0, 32'h3000_0050, 32'h0, 4'hF, model_rdat, 1'b1, 8, -1);
        issue(0, 1'b1, 1'b0, 32'h3000_0050, 32'h0, 4'hF);

        // ACK in the limit cycle beats the watchdog
        @(negedge clk);
        ack_delay = 8;
        sub_data  = 32'h0BAD_CAFE;
        model_rdat = 32'h0BAD_CAFE;
        expect_tx(0, 1'b0, 32'h3000_0054, 32'h0, 4'hF, model_rdat, 1'b0, 8, -1);
        issue(0, 1'b1, 1'b0, 32'h3000_0054, 32'h0, 4'hF);
`endif

        // reset in the middle of a bus cycle
        @(negedge clk);
        ack_delay = -1;
        m.req_adr_i[0]  = 32'h3000_0060;
        m.req_sel_i[0]  = 4'hF;
        m.req_read_i[0] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (m.CYC_O) got = 1'b1;
        end
        chk("rst_test_cyc_seen", 64'(got), 64'h1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_cyc_drop", 64'(m.CYC_O), 64'h0);
        chk("async_stb_drop", 64'(m.STB_O), 64'h0);
        chk("async_no_done", 64'(m.req_done_o), 64'h0);
        chk("async_no_err", 64'(m.req_err_o), 64'h0);
        m.req_read_i[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_rdat = 32'h0;
        @(negedge clk);

        // channel 0 wins first after reset
        ack_delay = 1;
        sub_data  = 32'h2468_ACE0;
        expect_tx(0, 1'b1, 32'h0000_0100, 32'hA0A0_0001, 4'hF, model_rdat, 1'b0, 1, -1);
        model_rdat = 32'h2468_ACE0;
        expect_tx(1, 1'b0, 32'h0000_0200, 32'h0, 4'b1100, model_rdat, 1'b0, 1, 2);
        run_pair(1, 1);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
